bin_to_bcd_16: RTL and testbench

BIN_TO_BCD_16 -- requirements
Module: bin_to_bcd_16

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_add3.sv | 14 +
 rtl/bin_to_bcd_16.sv | 100 ++++++++++
 tb/tb_bin_to_bcd_16.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_pkg : shared state type and default sizes for the binary-to-BCD converter
// Revision: 1.0
// ---------------------------------------------------------------------------
package bcd_pkg;

  localparam int BIN_WIDTH  = 16;
  localparam int BCD_DIGITS = 5;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_add3 : double-dabble digit correction, adds 3 when the digit is >= 5
// Revision: 1.0
// ---------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bin_to_bcd_16 : sequential double-dabble converter, one bit per clock
// Revision: 1.0
// ---------------------------------------------------------------------------
module bin_to_bcd_16
  import bcd_pkg::*;
#(
  parameter int WIDTH  = BIN_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int            CW     = $clog2(WIDTH + 1);
  localparam int            BW     = DIGITS * 4;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [WIDTH-1:0]    r_shift;
  logic [BW-1:0]       r_work;
  logic [CW-1:0]       r_cnt;
  logic [BW-1:0]       r_bcd;
  logic                r_done;
  logic                w_ready;
  logic                w_last;
  logic [BW-1:0]       w_adj;
  logic [BW+WIDTH-1:0] w_wide;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .i_digit (r_work[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // The adjusted digits and the remaining binary bits shift as one register
  assign w_wide = {w_adj, r_shift} << 1;
  assign w_last = (r_state == CONVERT) && (r_cnt == C_LAST);

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (start) w_state_next = CONVERT;
      end
      CONVERT: begin
        if (r_cnt == C_LAST) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_shift <= bin;
          r_work  <= '0;
          r_cnt   <= '0;
        end
      end else begin
        r_work  <= w_wide[BW+WIDTH-1:WIDTH];
        r_shift <= w_wide[WIDTH-1:0];
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_bcd  <= w_wide[BW+WIDTH-1:WIDTH];
          r_done <= 1'b1;
        end
      end
    end
  end

  assign ready = w_ready;
  assign done  = r_done;
  assign bcd   = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_16 : vector table, corner sequences and random checks
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic        ready;
  logic        done;
  logic [19:0] bcd;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
  } vec_t;

  vec_t tbl[8];

  bin_to_bcd_16 #(.WIDTH(16), .DIGITS(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .ready (ready),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Decimal digits by plain division, packed four bits per digit
  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int          x;
    r = '0;
    x = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Waits for done after the accepting edge; returns edges counted or -1
  task automatic wait_done(output int lat, output bit rdy_low);
    lat     = -1;
    rdy_low = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (ready !== 1'b0) rdy_low = 1'b0;
    end
  endtask

  task automatic do_conv(input logic [15:0] v, input logic [19:0] exp, input string tag);
    int lat;
    bit rdy_low;
    check({tag, "_ready_idle"}, 32'(ready), 32'd1);
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    bin   = 16'($urandom);
    wait_done(lat, rdy_low);
    check({tag, "_latency"}, 32'(lat), 32'd16);
    check({tag, "_bcd"}, 32'(bcd), 32'(exp));
    check({tag, "_ready_busy"}, 32'(rdy_low), 32'd1);
    check({tag, "_ready_at_done"}, 32'(ready), 32'd1);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_bcd_hold"}, 32'(bcd), 32'(exp));
  endtask

  initial begin
    int  lat;
    bit  rdy_low;
    bit  spurious;
    int  v;
    bit  digits_ok;

    tbl[0] = '{16'd0,     20'h00000};
    tbl[1] = '{16'd20000, 20'h20000};
    tbl[2] = '{16'd65025, 20'h65025};
    tbl[3] = '{16'd65535, 20'h65535};
    tbl[4] = '{16'd1,     20'h00001};
    tbl[5] = '{16'd9,     20'h00009};
    tbl[6] = '{16'd10,    20'h00010};
    tbl[7] = '{16'd59999, 20'h59999};

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    tick();
    tick();
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd", 32'(bcd), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) do_conv(tbl[i].bin, tbl[i].bcd, $sformatf("vec%0d", i));

    // Start issued mid-conversion must be ignored
    start = 1'b1;
    bin   = 16'd675;
    tick();
    start = 1'b0;
    bin   = 16'd1;
    for (int n = 1; n <= 4; n++) tick();
    start = 1'b1;
    bin   = 16'd9999;
    tick();
    start = 1'b0;
    lat = -1;
    for (int n = 6; n <= 40; n++) begin
      tick();
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    check("ignore_latency", 32'(lat), 32'd16);
    check("ignore_bcd", 32'(bcd), 32'h00675);
    spurious = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (done !== 1'b0 || ready !== 1'b1) spurious = 1'b1;
    end
    check("ignore_no_second_done", 32'(spurious), 32'd0);
    check("ignore_bcd_hold", 32'(bcd), 32'h00675);

    // Back-to-back: start held high through the done cycle
    start = 1'b1;
    bin   = 16'd510;
    tick();
    bin = 16'd50;
    wait_done(lat, rdy_low);
    check("b2b_first_latency", 32'(lat), 32'd16);
    check("b2b_first_bcd", 32'(bcd), 32'h00510);
    check("b2b_ready_at_done", 32'(ready), 32'd1);
    tick();
    start = 1'b0;
    bin   = 16'd7;
    wait_done(lat, rdy_low);
    check("b2b_second_gap", 32'(lat + 1), 32'd17);
    check("b2b_second_bcd", 32'(bcd), 32'h00050);
    tick();

    // Reset at edge 8 aborts the conversion
    start = 1'b1;
    bin   = 16'd12345;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 7; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    spurious = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (done !== 1'b0) spurious = 1'b1;
    end
    check("abort_no_done", 32'(spurious), 32'd0);

    // Start coincident with reset is discarded
    rst   = 1'b1;
    start = 1'b1;
    bin   = 16'd4321;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("rst_start_discard", 32'(ready), 32'd1);
    do_conv(16'd12345, 20'h12345, "after_abort");

    // Random conversions against the arithmetic model
    digits_ok = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      v = int'($urandom_range(0, 65535));
      start = 1'b1;
      bin   = 16'(v);
      tick();
      start = 1'b0;
      bin   = 16'($urandom);
      wait_done(lat, rdy_low);
      check("rand_latency", 32'(lat), 32'd16);
      check($sformatf("rand_bcd_%0d", v), 32'(bcd), 32'(ref_bcd(v)));
      for (int k = 0; k < 5; k++)
        if (bcd[4*k +: 4] > 4'd9) digits_ok = 1'b0;
    end
    check("rand_digit_range", 32'(digits_ok), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
